// File: rtl/servo_pkg.sv
// Shared widths, FSM state type and a position clamp helper for the servo
// slew controller.
package servo_pkg;

  localparam int POS_W  = 10;
  localparam int STEP_W = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } servo_state_t;

  function automatic int clamp_int(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running PWM frame counter; frame_tick marks the last cycle of a frame.
module servo_frame_timer #(
  parameter int FRAME_CYCLES = 1048576
) (
  input  logic clk,
  input  logic clr,
  output logic frame_tick
);

  localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Gated by clr so a single-cycle frame still reports no tick in reset.
  assign frame_tick = (cnt_reg == LAST) && !clr;

endmodule

// File: rtl/servo_slew_ctrl.sv
// Slew-limited servo position controller: one-entry command buffer, position
// stepped toward the target once per PWM frame, updated at the frame boundary.
module servo_slew_ctrl
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES = 1048576,
  parameter int POS_MIN      = 0,
  parameter int POS_MAX      = 1023,
  parameter int POS_RESET    = 512
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [POS_W-1:0]  cmd_pos,
  input  logic [STEP_W-1:0] cmd_step,
  input  logic              hold,
  output logic [POS_W-1:0]  pos,
  output logic              frame_tick,
  output logic              moving,
  output logic              at_target
);

  localparam logic [POS_W-1:0] LO_POS    = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] HI_POS    = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] RESET_POS = POS_W'(clamp_int(POS_RESET, POS_MIN, POS_MAX));

  logic [POS_W-1:0]  pos_reg, target_reg, pend_pos_reg;
  logic [STEP_W-1:0] step_reg, pend_step_reg;
  logic              pend_valid_reg;
  servo_state_t      state_reg, state_next;

  logic               upd, accept;
  logic [POS_W-1:0]   cmd_clamped, eff_target, pos_next;
  logic [STEP_W-1:0]  eff_step;
  logic signed [11:0] diff, mag;

  servo_frame_timer #(
    .FRAME_CYCLES (FRAME_CYCLES)
  ) u_timer (
    .clk        (clk),
    .clr        (clr),
    .frame_tick (frame_tick)
  );

  assign upd    = frame_tick && !hold;
  assign accept = cmd_valid && !pend_valid_reg;

  assign cmd_clamped = (cmd_pos < LO_POS) ? LO_POS :
                       ((cmd_pos > HI_POS) ? HI_POS : cmd_pos);

  // A pending command takes effect in the same tick that consumes it.
  assign eff_target = pend_valid_reg ? pend_pos_reg  : target_reg;
  assign eff_step   = pend_valid_reg ? pend_step_reg : step_reg;

  always_comb begin
    diff = $signed({2'b00, eff_target}) - $signed({2'b00, pos_reg});
    mag  = (diff < 0) ? -diff : diff;
    if ((eff_step == '0) || (mag <= $signed({6'b000000, eff_step}))) begin
      pos_next = eff_target;
    end else if (diff > 0) begin
      pos_next = pos_reg + {{(POS_W-STEP_W){1'b0}}, eff_step};
    end else begin
      pos_next = pos_reg - {{(POS_W-STEP_W){1'b0}}, eff_step};
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pos_reg        <= RESET_POS;
      target_reg     <= RESET_POS;
      step_reg       <= '0;
      pend_pos_reg   <= RESET_POS;
      pend_step_reg  <= '0;
      pend_valid_reg <= 1'b0;
    end else begin
      // Accept and consume are exclusive: accept needs an empty buffer.
      if (accept) begin
        pend_pos_reg   <= cmd_clamped;
        pend_step_reg  <= cmd_step;
        pend_valid_reg <= 1'b1;
      end else if (upd && pend_valid_reg) begin
        pend_valid_reg <= 1'b0;
      end
      if (upd) begin
        pos_reg    <= pos_next;
        target_reg <= eff_target;
        step_reg   <= eff_step;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    moving     = (state_reg == RAMP);
    if (upd) begin
      state_next = (pos_next != eff_target) ? RAMP : IDLE;
    end
  end

  assign pos       = pos_reg;
  assign cmd_ready = !pend_valid_reg;
  assign at_target = (pos_reg == target_reg) && !pend_valid_reg;

endmodule

// File: doc/servo_slew_ctrl.md
SERVO_SLEW_CTRL -- requirements
Module: servo_slew_ctrl

Interface
REQ-001 Parameter FRAME_CYCLES, default 1048576: PWM frame length in clk cycles; matches the downstream servo PWM counter wrap.
REQ-002 Parameter POS_MIN, default 0: lowest legal position; POS_MIN <= POS_MAX.
REQ-003 Parameter POS_MAX, default 1023: highest legal position.
REQ-004 Parameter POS_RESET, default 512: position after reset, clamped to [POS_MIN, POS_MAX].
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 clr  input  1  reset, asynchronous, active-high.
REQ-007 cmd_valid  input  1  new command offered.
REQ-008 cmd_ready  output  1  command buffer free; a command is accepted when cmd_valid and cmd_ready are both high on a rising edge.
REQ-009 cmd_pos  input  10  requested target position.
REQ-010 cmd_step  input  6  maximum change per frame; 0 means jump directly.
REQ-011 hold  input  1  freeze motion and command transfer while high.
REQ-012 pos  output  10  registered position to the downstream PWM generator.
REQ-013 frame_tick  output  1  one-cycle pulse on the last cycle of each frame.
REQ-014 moving  output  1  high while pos != active target.
REQ-015 at_target  output  1  high when pos == active target and no command is pending.

Function
REQ-016 Frame counter counts 0..FRAME_CYCLES-1 and wraps to 0; frame_tick is high exactly when the count equals FRAME_CYCLES-1.
REQ-017 One-entry pending buffer (pend_pos, pend_step, pend_valid); cmd_ready = !pend_valid, driven from the register with no combinational path from cmd_valid.
REQ-018 On acceptance, cmd_pos is clamped to [POS_MIN, POS_MAX] before it is stored, and pend_valid sets on the next edge.
REQ-019 pos, the active target and the step change only on a frame_tick cycle with hold low; on every other cycle they hold their values.
REQ-020 On an update tick with pend_valid set, the active target and step are loaded from the buffer, pend_valid clears, and pos moves toward the new target in that same tick.
REQ-021 Move rule: if step == 0 or |target - pos| <= step, pos_next = target; otherwise pos_next = pos ± step toward target.
REQ-022 Difference arithmetic uses at least 11-bit signed width; pos never wraps and never leaves [POS_MIN, POS_MAX].
REQ-023 The updated pos is visible on the cycle after frame_tick, at frame count 0, so the downstream PWM never sees a mid-frame change.
REQ-024 State machine IDLE/RAMP:
- IDLE: pos == target.
- IDLE -> RAMP: a tick loads a target different from pos.
- RAMP -> IDLE: the tick that makes pos == target.
- moving = (state == RAMP).
REQ-025 Simultaneous acceptance and tick with the buffer empty: the command is stored only; it is consumed at the next eligible tick.
REQ-026 A new command accepted during RAMP retargets at the next tick; reversal of direction is permitted.
REQ-027 A tick with hold high is skipped entirely: no pos change, no buffer transfer. The frame counter keeps running.
REQ-028 cmd_valid while cmd_ready is low is ignored; the upstream holds the command until it is accepted.

Reset
REQ-029 While clr is high, and immediately on its assertion:
- frame counter = 0
- pos = target = clamped POS_RESET
- step = 0
- pend_valid = 0
- state = IDLE
REQ-030 Output values during reset: cmd_ready = 1, frame_tick = 0, moving = 0, at_target = 1.
REQ-031 clr asserted mid-ramp discards the active and pending commands with no residual motion after release.

Structure
REQ-032 Shared package servo_pkg holds POS_W = 10, STEP_W = 6 and the IDLE/RAMP state type.
REQ-033 The frame counter and frame_tick live in a sub-module servo_frame_timer (parameter FRAME_CYCLES, ports clk, clr, frame_tick).

Verification (bench uses FRAME_CYCLES = 16)
REQ-034 Reset release -> pos = 512, cmd_ready = 1, at_target = 1, moving = 0; first frame_tick at cycle 15.
REQ-035 cmd_pos = 600, cmd_step = 10 -> pos reads 522, 532, ..., 592, 600 on successive ticks (9 ticks); moving drops with 600.
REQ-036 cmd_pos = 100, cmd_step = 0 -> pos = 100 after one tick; moving never asserts.
REQ-037 POS_MAX = 900, cmd_pos = 1023, cmd_step = 63 -> pos reads 575, 638, ... and stops at 900.
REQ-038 Second command (cmd_pos = 550) offered while pending -> cmd_ready = 0 until the tick consumes the first; retarget mid-ramp from 560 toward 550 reverses; hold high over 3 ticks -> pos unchanged.
REQ-039 clr pulsed mid-ramp at pos = 552 -> pos = 512, pend_valid = 0 at once; no motion on subsequent ticks.
